traffic_light_safety_monitor: RTL and testbench

//  Downstream of traffic_light_controller: samples its six lamp outputs, checks safety invariants

---
 rtl/traffic_light_safety_monitor_pkg.sv | 13 +
 rtl/traffic_light_safety_monitor_if.sv | 21 ++
 rtl/traffic_light_safety_monitor_checker.sv | 31 +++
 rtl/traffic_light_safety_monitor.sv | 75 +++++++
 tb/tb_traffic_light_safety_monitor.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/traffic_light_safety_monitor_pkg.sv
// traffic_pkg: shared lamp, fault-code and monitor-state types
package traffic_pkg;
  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamp_t;
  typedef enum logic [2:0] {NONE, CONFLICT, NOT_ONEHOT, BAD_SEQ, SHORT_YEL, WATCHDOG} fault_code_e;
  typedef enum logic [1:0] {INIT, RUN, FAULT} mon_state_e;
  localparam lamp_t LAMP_R = 3'b100;
  localparam lamp_t LAMP_Y = 3'b010;
  localparam lamp_t LAMP_G = 3'b001;
endpackage

// File: rtl/traffic_light_safety_monitor_if.sv
// traffic_light_safety_monitor_if: controller lamps in, driver lamps and fault status out
interface traffic_light_safety_monitor_if;
  import traffic_pkg::*;
  logic main_red, main_yellow, main_green;
  logic side_red, side_yellow, side_green;
  logic fault_clr;
  logic out_main_red, out_main_yellow, out_main_green;
  logic out_side_red, out_side_yellow, out_side_green;
  logic fault;
  fault_code_e fault_code;
  modport master (
    output main_red, main_yellow, main_green, side_red, side_yellow, side_green, fault_clr,
    input out_main_red, out_main_yellow, out_main_green,
    input out_side_red, out_side_yellow, out_side_green, fault, fault_code
  );
  modport slave (
    input main_red, main_yellow, main_green, side_red, side_yellow, side_green, fault_clr,
    output out_main_red, out_main_yellow, out_main_green,
    output out_side_red, out_side_yellow, out_side_green, fault, fault_code
  );
endinterface

// File: rtl/traffic_light_safety_monitor_checker.sv
// lamp_sequence_checker: per-road one-hot, step-legality and yellow-hold checks of S against P
module lamp_sequence_checker
  import traffic_pkg::*;
#(
  parameter int MIN_YELLOW_CYCLES = 3
) (
  input  logic  clk,
  input  logic  rst,
  input  lamp_t s,
  output lamp_t p,
  output logic  onehot_err,
  output logic  seq_err,
  output logic  short_yel_err
);
  localparam int YW = $clog2(MIN_YELLOW_CYCLES + 1);
  logic [YW-1:0] ycnt;
  // previous sample and count of consecutive yellow samples, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      p    <= LAMP_R;
      ycnt <= '0;
    end else begin
      p    <= s;
      ycnt <= !s.yellow ? '0 : ycnt == YW'(MIN_YELLOW_CYCLES) ? ycnt : ycnt + 1'b1;
    end
  end
  assign onehot_err    = $countones(s) != 1;
  assign seq_err       = s != p && !(p == LAMP_R && s == LAMP_G) &&
                         !(p == LAMP_G && s == LAMP_Y) && !(p == LAMP_Y && s == LAMP_R);
  assign short_yel_err = p == LAMP_Y && s == LAMP_R && ycnt < YW'(MIN_YELLOW_CYCLES);
endmodule

// File: rtl/traffic_light_safety_monitor.sv
// traffic_light_safety_monitor: last stage before lamp drivers; checks invariants, latches faults, flashes red
module traffic_light_safety_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_YELLOW_CYCLES = 3,
  parameter int MAX_PHASE_CYCLES  = 64,
  parameter int FLASH_HALF_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  traffic_light_safety_monitor_if.slave bus
);
  localparam int IW = $clog2(MAX_PHASE_CYCLES + 1);
  localparam int FW = $clog2(FLASH_HALF_CYCLES);
  lamp_t s_main, s_side, p_main, p_side, out_m, out_s;
  logic oh_m, oh_s, seq_m, seq_s, sy_m, sy_s;
  logic conflict, wd, chk_seq, fail, clr_ok, flash_run, phase;
  logic [IW-1:0] idle;
  logic [FW-1:0] fcnt;
  mon_state_e state, nstate;
  fault_code_e hit, code_q, code_d;
  lamp_sequence_checker #(.MIN_YELLOW_CYCLES(MIN_YELLOW_CYCLES)) u_main (
    .clk(clk), .rst(rst), .s(s_main), .p(p_main),
    .onehot_err(oh_m), .seq_err(seq_m), .short_yel_err(sy_m)
  );
  lamp_sequence_checker #(.MIN_YELLOW_CYCLES(MIN_YELLOW_CYCLES)) u_side (
    .clk(clk), .rst(rst), .s(s_side), .p(p_side),
    .onehot_err(oh_s), .seq_err(seq_s), .short_yel_err(sy_s)
  );
  // sample register, FSM state, fault code, idle watchdog and flash generator
  always_ff @(posedge clk) begin
    if (rst) begin
      s_main <= LAMP_R;
      s_side <= LAMP_R;
      state  <= INIT;
      code_q <= NONE;
      idle   <= '0;
      fcnt   <= '0;
      phase  <= 1'b1;
    end else begin
      s_main <= {bus.main_red, bus.main_yellow, bus.main_green};
      s_side <= {bus.side_red, bus.side_yellow, bus.side_green};
      state  <= nstate;
      code_q <= code_d;
      idle   <= (s_main != p_main || s_side != p_side) ? '0 :
                idle == IW'(MAX_PHASE_CYCLES) ? idle : idle + 1'b1;
      fcnt   <= !flash_run ? '0 : fcnt == FW'(FLASH_HALF_CYCLES - 1) ? '0 : fcnt + 1'b1;
      phase  <= !flash_run ? 1'b1 : phase ^ (fcnt == FW'(FLASH_HALF_CYCLES - 1));
    end
  end
  // checks, priority encode, next state and lamp output mux
  always_comb begin
    conflict  = (s_main.green | s_main.yellow) & (s_side.green | s_side.yellow);
    wd        = idle == IW'(MAX_PHASE_CYCLES);
    chk_seq   = state != INIT;
    hit       = conflict ? CONFLICT : (oh_m | oh_s) ? NOT_ONEHOT :
                (chk_seq && (seq_m | seq_s)) ? BAD_SEQ :
                (chk_seq && (sy_m | sy_s)) ? SHORT_YEL : wd ? WATCHDOG : NONE;
    fail      = hit != NONE;
    clr_ok    = bus.fault_clr && !fail;
    nstate    = state == FAULT ? (clr_ok ? INIT : FAULT) : (fail ? FAULT : RUN);
    code_d    = state == FAULT ? (clr_ok ? NONE : code_q) : (fail ? hit : NONE);
    flash_run = state == FAULT && nstate == FAULT;
    out_m     = state == FAULT ? lamp_t'({phase, 2'b00}) : fail ? LAMP_R : s_main;
    out_s     = state == FAULT ? lamp_t'({phase, 2'b00}) : fail ? LAMP_R : s_side;
  end
  assign bus.out_main_red    = out_m.red;
  assign bus.out_main_yellow = out_m.yellow;
  assign bus.out_main_green  = out_m.green;
  assign bus.out_side_red    = out_s.red;
  assign bus.out_side_yellow = out_s.yellow;
  assign bus.out_side_green  = out_s.green;
  assign bus.fault           = state == FAULT;
  assign bus.fault_code      = code_q;
endmodule

// File: tb/tb_traffic_light_safety_monitor.sv
// tb_traffic_light_safety_monitor: directed and random lamp streams against a rule-level reference model
module tb_traffic_light_safety_monitor;
  import traffic_pkg::*;
  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  traffic_light_safety_monitor_if bus ();
  traffic_light_safety_monitor dut (.clk(clk), .rst(rst), .bus(bus));
  int n_cmp = 0, n_err = 0;
  logic [2:0] ms[2], mp[2];
  int mode, mcode, stable, age;
  int yheld[2];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic legal(input logic [2:0] p, input logic [2:0] s);
    return p == s || (p == R && s == G) || (p == G && s == Y) || (p == Y && s == R);
  endfunction
  function automatic int model_hit();
    if ((ms[0][1] | ms[0][0]) & (ms[1][1] | ms[1][0])) return 1;
    if ($countones(ms[0]) != 1 || $countones(ms[1]) != 1) return 2;
    if (mode != 0 && (!legal(mp[0], ms[0]) || !legal(mp[1], ms[1]))) return 3;
    for (int r = 0; r < 2; r++)
      if (mode != 0 && mp[r] == Y && ms[r] == R && yheld[r] < 3) return 4;
    if (stable >= 64) return 5;
    return 0;
  endfunction
  function automatic logic [5:0] dut_lamps();
    return {bus.out_main_red, bus.out_main_yellow, bus.out_main_green,
            bus.out_side_red, bus.out_side_yellow, bus.out_side_green};
  endfunction
  function automatic logic [3:0] dut_status();
    return {bus.fault, bus.fault_code};
  endfunction
  task automatic drive(input logic [2:0] m, input logic [2:0] s, input logic clr);
    {bus.main_red, bus.main_yellow, bus.main_green} = m;
    {bus.side_red, bus.side_yellow, bus.side_green} = s;
    bus.fault_clr = clr;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    drive(R, R, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    ms[0] = R; ms[1] = R; mp[0] = R; mp[1] = R;
    yheld[0] = 0; yheld[1] = 0;
    mode = 0; mcode = 0; stable = 0; age = 0;
  endtask
  task automatic cyc(input logic [2:0] m, input logic [2:0] s, input logic clr);
    int h;
    logic ph;
    logic [2:0] em, es;
    h = model_hit();
    ph = ((age / 4) % 2) == 0;
    if (mode == 2) begin
      em = {ph, 2'b00};
      es = {ph, 2'b00};
    end else if (h != 0) begin
      em = R;
      es = R;
    end else begin
      em = ms[0];
      es = ms[1];
    end
    check("lamps", 32'(dut_lamps()), 32'({em, es}));
    check("status", 32'(dut_status()), 32'({mode == 2, 3'(mcode)}));
    drive(m, s, clr);
    if (mode == 2) begin
      if (clr && h == 0) begin
        mode = 0;
        mcode = 0;
      end else age++;
    end else if (h != 0) begin
      mode = 2;
      mcode = h;
      age = 0;
    end else mode = 1;
    stable = (ms[0] == mp[0] && ms[1] == mp[1]) ? (stable < 64 ? stable + 1 : 64) : 0;
    for (int r = 0; r < 2; r++) yheld[r] = ms[r][1] ? yheld[r] + 1 : 0;
    mp[0] = ms[0]; mp[1] = ms[1];
    ms[0] = m; ms[1] = s;
    @(negedge clk);
  endtask
  task automatic hold(input logic [2:0] m, input logic [2:0] s, input int n);
    for (int i = 0; i < n; i++) cyc(m, s, 1'b0);
  endtask
  initial begin
    int ph, dur;
    logic [2:0] rm, rs;
    do_reset();
    check("rst_lamps", 32'(dut_lamps()), 32'(6'b100100));
    check("rst_status", 32'(dut_status()), 32'(0));
    for (int k = 0; k < 2; k++) begin
      hold(G, R, 10); hold(Y, R, 3); hold(R, G, 10); hold(R, Y, 3);
    end
    check("legal_no_fault", 32'(dut_status()), 32'(0));
    cyc(G, G, 1'b0);
    check("conflict_red_now", 32'(dut_lamps()), 32'(6'b100100));
    cyc(R, R, 1'b0);
    check("conflict_code", 32'(dut_status()), 32'({1'b1, 3'd1}));
    hold(R, R, 12);
    cyc(R, R, 1'b1);
    hold(R, R, 2);
    check("clear_ok", 32'(dut_status()), 32'(0));
    hold(G, R, 5); hold(Y, R, 2); hold(R, R, 3);
    check("short_yel", 32'(dut_status()), 32'({1'b1, 3'd4}));
    cyc(R, R, 1'b1);
    hold(R, R, 2);
    hold(G, R, 3); hold(R, R, 3);
    check("bad_seq", 32'(dut_status()), 32'({1'b1, 3'd3}));
    cyc(R, R, 1'b1);
    hold(R, R, 2);
    hold(G, R, 64); hold(Y, R, 3);
    check("wd_edge_ok", 32'(dut_status()), 32'(0));
    hold(R, R, 80);
    check("watchdog", 32'(dut_status()), 32'({1'b1, 3'd5}));
    cyc(R, R, 1'b1);
    hold(R, R, 2);
    check("clr_vs_fault", 32'(dut_status()), 32'({1'b1, 3'd5}));
    hold(G, R, 3);
    cyc(G, R, 1'b1);
    hold(G, R, 3);
    check("clr_after_change", 32'(dut_status()), 32'(0));
    cyc(3'b110, G, 1'b0);
    hold(R, R, 3);
    check("priority", 32'(dut_status()), 32'({1'b1, 3'd1}));
    hold(R, R, 5);
    do_reset();
    check("rst_flash_lamps", 32'(dut_lamps()), 32'(6'b100100));
    check("rst_flash_status", 32'(dut_status()), 32'(0));
    ph = 0;
    dur = 5;
    for (int t = 0; t < 4000; t++) begin
      if (dur == 0) begin
        ph = (ph + 1) % 4;
        dur = (ph % 2 == 1) ? int'($urandom_range(1, 4)) : int'($urandom_range(1, 12));
        if ($urandom_range(0, 99) == 0) dur = 70;
      end
      dur--;
      rm = ph == 0 ? G : ph == 1 ? Y : R;
      rs = ph == 2 ? G : ph == 3 ? Y : R;
      if ($urandom_range(0, 49) == 0) begin
        rm = 3'($urandom);
        rs = 3'($urandom);
      end
      if ($urandom_range(0, 999) == 0) do_reset();
      else cyc(rm, rs, mode == 2 && $urandom_range(0, 5) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
